// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
//
// Turns store requests from the MEM stage into registered, byte-strobed write
// beats for the data memory. A store whose bytes run past the end of a memory
// word is issued as two consecutive beats: the low part at the request's word
// index and the high part at the next word index (wrapping at the top index).
// Store sizes wider than the memory word are consumed and flagged on req_err
// without touching memory.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    store request valid
//   req_ready    request can be accepted this cycle (combinational)
//   req_addr     byte address of the store
//   req_func3    RISC-V store funct3; [1:0] is the size code, [2] ignored
//   req_data     right-justified store data
//   req_err      one-cycle pulse after an oversized store is consumed
//   mem_valid    write beat valid
//   mem_ready    memory accepts the current beat
//   mem_addr     word index of the beat
//   mem_wstrb    per-byte write enables
//   mem_wdata    lane-shifted write data, zero outside the enabled lanes
//   busy         second beat of a split store is still pending
//   split_cnt    split stores accepted since reset, saturating
// -----------------------------------------------------------------------------
module store_align_unit #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int MEM_AW = 13,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_func3,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  split_cnt
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // Byte mask of a store of the given size code, right-justified.
    function automatic logic [NB-1:0] size_mask(input logic [1:0] code);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < (1 << code));
        end
        return m;
    endfunction

    // Registered state and outputs
    state_t              state_r;
    logic                mem_valid_r;
    logic [MEM_AW-1:0]   mem_addr_r;
    logic [NB-1:0]       mem_wstrb_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                req_err_r;
    logic [CNT_W-1:0]    split_cnt_r;
    logic [MEM_AW-1:0]   hi_addr_r;
    logic [NB-1:0]       hi_strb_r;
    logic [DATA_W-1:0]   hi_data_r;

    // Next-state values
    state_t              state_nxt_s;
    logic                mem_valid_nxt_s;
    logic [MEM_AW-1:0]   mem_addr_nxt_s;
    logic [NB-1:0]       mem_wstrb_nxt_s;
    logic [DATA_W-1:0]   mem_wdata_nxt_s;
    logic                req_err_nxt_s;
    logic [CNT_W-1:0]    split_cnt_nxt_s;
    logic [MEM_AW-1:0]   hi_addr_nxt_s;
    logic [NB-1:0]       hi_strb_nxt_s;
    logic [DATA_W-1:0]   hi_data_nxt_s;

    // Per-request arithmetic
    logic [3:0]          size_s;
    logic                illegal_s;
    logic [OFS_W-1:0]    ofs_s;
    logic [MEM_AW-1:0]   idx_s;
    logic [NB-1:0]       byte_mask_s;
    logic [DATA_W-1:0]   data_mask_s;
    logic [2*NB-1:0]     mask2_s;
    logic [2*DATA_W-1:0] data2_s;
    logic                accept_s;
    logic                beat_done_s;
    logic                unused_s;

    assign size_s      = 4'd1 << req_func3[1:0];
    assign illegal_s   = (int'(size_s) > NB);
    assign ofs_s       = req_addr[OFS_W-1:0];
    assign idx_s       = req_addr[OFS_W+MEM_AW-1:OFS_W];
    assign byte_mask_s = size_mask(req_func3[1:0]);

    // Widen the byte mask to a bit mask so unused data bytes are dropped
    always_comb begin
        data_mask_s = '0;
        for (int i = 0; i < NB; i++) begin
            data_mask_s[i*8 +: 8] = {8{byte_mask_s[i]}};
        end
    end

    // Double-width shift: the upper halves hold whatever spills into the next word
    assign mask2_s = {{NB{1'b0}}, byte_mask_s} << ofs_s;
    assign data2_s = {{DATA_W{1'b0}}, req_data & data_mask_s} << {ofs_s, 3'b000};

    assign req_ready   = (state_r == IDLE) && (!mem_valid_r || mem_ready);
    assign accept_s    = req_valid && req_ready;
    assign beat_done_s = mem_valid_r && mem_ready;

    assign unused_s = ^{req_func3[2], req_addr};

    // Next-state and next-output logic for the IDLE/SPLIT controller
    always_comb begin
        state_nxt_s     = state_r;
        mem_valid_nxt_s = mem_valid_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wstrb_nxt_s = mem_wstrb_r;
        mem_wdata_nxt_s = mem_wdata_r;
        req_err_nxt_s   = 1'b0;
        split_cnt_nxt_s = split_cnt_r;
        hi_addr_nxt_s   = hi_addr_r;
        hi_strb_nxt_s   = hi_strb_r;
        hi_data_nxt_s   = hi_data_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (illegal_s) begin
                        // Acceptance implies any previous beat was consumed.
                        req_err_nxt_s   = 1'b1;
                        mem_valid_nxt_s = 1'b0;
                    end else begin
                        mem_valid_nxt_s = 1'b1;
                        mem_addr_nxt_s  = idx_s;
                        mem_wstrb_nxt_s = mask2_s[NB-1:0];
                        mem_wdata_nxt_s = data2_s[DATA_W-1:0];
                        if (mask2_s[2*NB-1:NB] != '0) begin
                            state_nxt_s   = SPLIT;
                            hi_addr_nxt_s = idx_s + MEM_AW'(1);
                            hi_strb_nxt_s = mask2_s[2*NB-1:NB];
                            hi_data_nxt_s = data2_s[2*DATA_W-1:DATA_W];
                            if (split_cnt_r != '1) begin
                                split_cnt_nxt_s = split_cnt_r + CNT_W'(1);
                            end else begin
                                split_cnt_nxt_s = split_cnt_r;
                            end
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
                end else if (beat_done_s) begin
                    mem_valid_nxt_s = 1'b0;
                end else begin
                    mem_valid_nxt_s = mem_valid_r;
                end
            end
            SPLIT: begin
                if (beat_done_s) begin
                    state_nxt_s     = IDLE;
                    mem_valid_nxt_s = 1'b1;
                    mem_addr_nxt_s  = hi_addr_r;
                    mem_wstrb_nxt_s = hi_strb_r;
                    mem_wdata_nxt_s = hi_data_r;
                end else begin
                    state_nxt_s = SPLIT;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                mem_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wstrb_r <= '0;
            mem_wdata_r <= '0;
            req_err_r   <= 1'b0;
            split_cnt_r <= '0;
            hi_addr_r   <= '0;
            hi_strb_r   <= '0;
            hi_data_r   <= '0;
        end else begin
            state_r     <= state_nxt_s;
            mem_valid_r <= mem_valid_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wstrb_r <= mem_wstrb_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            req_err_r   <= req_err_nxt_s;
            split_cnt_r <= split_cnt_nxt_s;
            hi_addr_r   <= hi_addr_nxt_s;
            hi_strb_r   <= hi_strb_nxt_s;
            hi_data_r   <= hi_data_nxt_s;
        end
    end

    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wstrb = mem_wstrb_r;
    assign mem_wdata = mem_wdata_r;
    assign req_err   = req_err_r;
    assign split_cnt = split_cnt_r;
    assign busy      = (state_r == SPLIT);

endmodule

// File: tb/tb_store_align_unit.sv
// -----------------------------------------------------------------------------
// tb_store_align_unit
//
// Drives a 64-bit and a 32-bit store_align_unit with directed stores. Each
// expected write beat is queued when its request is issued; monitors pop and
// compare whenever a beat is consumed (mem_valid && mem_ready).
// -----------------------------------------------------------------------------
module tb_store_align_unit;

    typedef struct {
        logic [12:0] a;
        logic [7:0]  s;
        logic [63:0] d;
    } beat_t;

    logic        clk;
    logic        rst;

    // 64-bit instance
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [2:0]  req_func3;
    logic [63:0] req_data;
    logic        req_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        busy;
    logic [15:0] split_cnt;

    // 32-bit instance
    logic        req_valid32;
    logic        req_ready32;
    logic [63:0] req_addr32;
    logic [2:0]  req_func332;
    logic [31:0] req_data32;
    logic        req_err32;
    logic        mem_valid32;
    logic        mem_ready32;
    logic [12:0] mem_addr32;
    logic [3:0]  mem_wstrb32;
    logic [31:0] mem_wdata32;
    logic        busy32;
    logic [15:0] split_cnt32;

    int n_checks = 0;
    int n_pass   = 0;
    beat_t q64[$];
    beat_t q32[$];

    store_align_unit #(.DATA_W(64)) u64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_func3(req_func3), .req_data(req_data), .req_err(req_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .busy(busy),
        .split_cnt(split_cnt)
    );

    store_align_unit #(.DATA_W(32)) u32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid32), .req_ready(req_ready32), .req_addr(req_addr32),
        .req_func3(req_func332), .req_data(req_data32), .req_err(req_err32),
        .mem_valid(mem_valid32), .mem_ready(mem_ready32), .mem_addr(mem_addr32),
        .mem_wstrb(mem_wstrb32), .mem_wdata(mem_wdata32), .busy(busy32),
        .split_cnt(split_cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push64(input logic [12:0] a, input logic [7:0] s, input logic [63:0] d);
        beat_t b;
        b.a = a; b.s = s; b.d = d;
        q64.push_back(b);
    endtask

    task automatic push32(input logic [12:0] a, input logic [7:0] s, input logic [63:0] d);
        beat_t b;
        b.a = a; b.s = s; b.d = d;
        q32.push_back(b);
    endtask

    // Present a request and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send64(input logic [63:0] a, input logic [2:0] f, input logic [63:0] d);
        int waits;
        waits = 0;
        req_valid = 1'b1; req_addr = a; req_func3 = f; req_data = d;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL accept64_timeout: req_ready stayed %b, required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = '1; req_func3 = 3'b011; req_data = '1;
    endtask

    task automatic send32(input logic [63:0] a, input logic [2:0] f, input logic [31:0] d);
        int waits;
        waits = 0;
        req_valid32 = 1'b1; req_addr32 = a; req_func332 = f; req_data32 = d;
        @(negedge clk);
        while (!req_ready32 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready32) begin
            n_checks++;
            $display("FAIL accept32_timeout: req_ready stayed %b, required 1", req_ready32);
        end
        @(posedge clk);
        #1;
        req_valid32 = 1'b0; req_addr32 = '1; req_func332 = 3'b000; req_data32 = '1;
    endtask

    // Scoreboard monitor for the 64-bit instance
    always @(negedge clk) begin
        if (!rst && mem_valid && mem_ready) begin
            if (q64.size() == 0) begin
                n_checks++;
                $display("FAIL beat64_unexpected: got addr %h strb %h data %h, required no beat",
                         mem_addr, mem_wstrb, mem_wdata);
            end else begin
                beat_t e;
                e = q64.pop_front();
                check("beat64_addr", 64'(mem_addr), 64'(e.a));
                check("beat64_strb", 64'(mem_wstrb), 64'(e.s));
                check("beat64_data", mem_wdata, e.d);
            end
        end
    end

    // Scoreboard monitor for the 32-bit instance
    always @(negedge clk) begin
        if (!rst && mem_valid32 && mem_ready32) begin
            if (q32.size() == 0) begin
                n_checks++;
                $display("FAIL beat32_unexpected: got addr %h strb %h data %h, required no beat",
                         mem_addr32, mem_wstrb32, mem_wdata32);
            end else begin
                beat_t e;
                e = q32.pop_front();
                check("beat32_addr", 64'(mem_addr32), 64'(e.a));
                check("beat32_strb", 64'(mem_wstrb32), 64'(e.s));
                check("beat32_data", 64'(mem_wdata32), e.d);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1; mem_ready32 = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_func3 = '0; req_data = '0;
        req_valid32 = 1'b0; req_addr32 = '0; req_func332 = '0; req_data32 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_req_err", 64'(req_err), 64'd0);
        check("rst_split_cnt", 64'(split_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // Single-beat stores, back to back
        push64(13'h0002, 8'h08, 64'h0000_0000_AB00_0000);
        send64(64'hDEAD_0000_0000_0013, 3'b000, 64'hFFFF_FFFF_FFFF_FFAB);
        push64(13'h0008, 8'hFF, 64'h0123_4567_89AB_CDEF);
        send64(64'h0000_0000_0000_0040, 3'b011, 64'h0123_4567_89AB_CDEF);
        check("b2b_valid_1", 64'(mem_valid), 64'd1);
        push64(13'h0004, 8'h0C, 64'h0000_0000_5566_0000);
        send64(64'h0000_0000_0000_0022, 3'b001, 64'hAAAA_AAAA_AAAA_5566);
        check("b2b_valid_2", 64'(mem_valid), 64'd1);
        push64(13'h0000, 8'h80, 64'h9900_0000_0000_0000);
        send64(64'h0000_0000_0000_0007, 3'b100, 64'h0000_0000_0000_0099);
        check("b2b_valid_3", 64'(mem_valid), 64'd1);
        @(posedge clk); #1;
        check("idle_valid_clear", 64'(mem_valid), 64'd0);

        // Misaligned sw at 0x0E splits across words 1 and 2
        push64(13'h0001, 8'hC0, 64'h3344_0000_0000_0000);
        push64(13'h0002, 8'h03, 64'h0000_0000_0000_1122);
        send64(64'h0000_0000_0000_000E, 3'b010, 64'hCAFE_BABE_1122_3344);
        check("split_busy", 64'(busy), 64'd1);
        check("split_req_ready", 64'(req_ready), 64'd0);
        check("split_cnt_1", 64'(split_cnt), 64'd1);
        @(posedge clk); #1;
        check("split_busy_done", 64'(busy), 64'd0);
        check("split_beat2_strb", 64'(mem_wstrb), 64'h03);
        @(posedge clk); #1;

        // Split sd at 0x05 under backpressure
        mem_ready = 1'b0;
        push64(13'h0000, 8'hE0, 64'h3322_1100_0000_0000);
        push64(13'h0001, 8'h1F, 64'h0000_0088_7766_5544);
        send64(64'h0000_0000_0000_0005, 3'b011, 64'h8877_6655_4433_2211);
        req_valid = 1'b1; req_addr = 64'h0000_0000_0000_0100; req_func3 = 3'b000; req_data = 64'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(mem_valid), 64'd1);
            check("bp_addr", 64'(mem_addr), 64'h0);
            check("bp_strb", 64'(mem_wstrb), 64'hE0);
            check("bp_data", mem_wdata, 64'h3322_1100_0000_0000);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("bp_beat1_still", 64'(mem_wstrb), 64'hE0);
        @(posedge clk); #1;
        check("bp_busy_done", 64'(busy), 64'd0);
        check("split_cnt_2", 64'(split_cnt), 64'd2);
        @(posedge clk); #1;

        // Split sh at the top word index wraps to index 0
        push64(13'h1FFF, 8'h80, 64'hEF00_0000_0000_0000);
        push64(13'h0000, 8'h01, 64'h0000_0000_0000_00BE);
        send64(64'h0000_0000_0000_FFFF, 3'b001, 64'h0000_0000_0000_BEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("split_cnt_3", 64'(split_cnt), 64'd3);

        // 32-bit instance: oversized store flags an error and issues nothing
        send32(64'h0000_0000_0000_0100, 3'b011, 32'h1234_5678);
        check("err32_pulse", 64'(req_err32), 64'd1);
        check("err32_no_beat", 64'(mem_valid32), 64'd0);
        check("err32_ready", 64'(req_ready32), 64'd1);
        @(posedge clk); #1;
        check("err32_pulse_end", 64'(req_err32), 64'd0);
        check("err32_still_no_beat", 64'(mem_valid32), 64'd0);

        // 32-bit instance: eight aligned sw back to back
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            d = 32'h0101_0101 * 32'(i + 1);
            push32(13'(i), 8'h0F, {32'h0, d});
            send32(64'(4 * i), 3'b010, d);
            check("sw32_no_bubble", 64'(mem_valid32), 64'd1);
        end
        @(posedge clk); #1;
        check("sw32_drained", 64'(mem_valid32), 64'd0);

        // Reset in the middle of a stalled split drops the second beat
        mem_ready = 1'b0;
        send64(64'h0000_0000_0000_000E, 3'b010, 64'h0000_0000_1122_3344);
        check("rst_split_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_split_valid", 64'(mem_valid), 64'd0);
        check("rst_split_busy_clr", 64'(busy), 64'd0);
        check("rst_split_cnt", 64'(split_cnt), 64'd0);
        check("rst_split_ready", 64'(req_ready), 64'd1);
        mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_second_beat", 64'(mem_valid), 64'd0);

        check("q64_empty", 64'(q64.size()), 64'd0);
        check("q32_empty", 64'(q32.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
Parametrised successor to the pipelined CPU's combinational store byte-lane unit. It accepts store requests from the MEM stage through a valid/ready handshake and emits registered, byte-strobed data-memory write beats. Misaligned stores that cross a memory word are split into two consecutive beats, which the original lane unit silently dropped. It sits between the MEM stage and the dmem write port.

Parameters:
DATA_W, 64, memory word width in bits; legal values 32 and 64. NB = DATA_W/8, OFS_W = log2(NB).
ADDR_W, 64, request address width.
MEM_AW, 13, memory word-index width; mem_addr = addr[OFS_W+MEM_AW-1:OFS_W].
CNT_W, 16, width of the split-store counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  store request valid
req_ready  out  1  unit can accept a request this cycle
req_addr  in  ADDR_W  byte address
req_func3  in  3  RISC-V store funct3; [1:0] is the size code (0=sb, 1=sh, 2=sw, 3=sd); [2] is ignored
req_data  in  DATA_W  store data, right-justified
req_err  out  1  one-cycle pulse: size exceeds NB, request consumed, no write issued
mem_valid  out  1  write beat valid
mem_ready  in  1  memory accepts the beat
mem_addr  out  MEM_AW  word index
mem_wstrb  out  NB  byte write enables
mem_wdata  out  DATA_W  lane-shifted write data
busy  out  1  state is SPLIT
split_cnt  out  CNT_W  number of split stores accepted since reset; saturates at all-ones

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; mem_valid=0; mem_addr, mem_wstrb, mem_wdata=0; req_err=0; split_cnt=0. A reset mid-split discards the pending second beat.
- FSM states are IDLE and SPLIT.
- req_ready = (state==IDLE) && (!mem_valid || mem_ready). This is combinational.
- A request is accepted when req_valid && req_ready.
- Per-request arithmetic:
  - size = 1<<func3[1:0]
  - ofs = req_addr[OFS_W-1:0]
  - mask2 (2*NB bits) = ((1<<size)-1) << ofs
  - data2 (2*DATA_W bits) = zero-extend(req_data masked to size*8 bits) << (ofs*8)
  - lo = low halves of mask2/data2; hi = high halves of mask2/data2.
- Illegal size (size > NB, e.g. sd when DATA_W=32): the request is accepted, req_err=1 on the next cycle, no beat is issued, and mem_valid deasserts if the previous beat was consumed.
- Single-beat store (hi mask == 0): at the next edge, mem_valid=1, mem_addr=idx, mem_wstrb=lo mask, mem_wdata=lo data. State stays IDLE. Latency is 1 cycle. Back-to-back stores sustain 1 per cycle while mem_ready=1.
- Split store (hi mask != 0):
  - The first beat is loaded as above.
  - The hi mask, hi data and idx+1 are latched in internal registers.
  - state goes to SPLIT and split_cnt increments.
- In SPLIT, req_ready=0. On mem_valid && mem_ready, the second beat is loaded: mem_addr=idx+1 modulo 2^MEM_AW (wraps at the top index), mem_wstrb=hi mask, mem_wdata=hi data. state returns to IDLE.
- mem_valid holds its value and all mem_* outputs stay stable while mem_valid && !mem_ready. mem_valid clears when a beat is consumed and no new beat is loaded in that cycle.
- Byte lanes outside mem_wstrb carry zero in mem_wdata.
- req_* inputs are sampled only at acceptance. Changes while req_ready=0 are ignored.

Test Plan:
- DATA_W=64: sb addr=0x...13, data=0xAB, mem_ready=1 -> 1 cycle later mem_valid=1, mem_addr=2, mem_wstrb=0x08, mem_wdata=0x00000000AB000000. Aligned sd at 0x40 -> mem_wstrb=0xFF, mem_addr=8.
- Misaligned sw at addr=0x0E, data=0x11223344, mem_ready=1:
  - beat 1: mem_addr=1, mem_wstrb=0xC0, mem_wdata=0x3344000000000000
  - beat 2: mem_addr=2, mem_wstrb=0x03, mem_wdata=0x1122
  - busy=1 during the split; split_cnt=1.
- Backpressure: hold mem_ready=0 for 3 cycles during a split sd at 0x05 -> beat 1 outputs stable and req_ready=0 throughout. Beat 2 (mem_wstrb=0x1F) appears only on the cycle after mem_ready=1.
- Wrap: sh at word index 0x1FFF, ofs=7 -> beats at mem_addr 0x1FFF (wstrb 0x80) and 0x0000 (wstrb 0x01).
- DATA_W=32: sd request -> req_err pulses 1 cycle, no mem_valid, req_ready stays 1. Then 8 back-to-back aligned sw with mem_ready=1 -> 8 consecutive beats with no bubbles.
- Assert rst while in SPLIT with mem_ready=0 -> next cycle mem_valid=0, busy=0, split_cnt=0, req_ready=1, and no second beat is ever issued.
